sf_camera_dma_ctrl: RTL
=======================

Name: sf_camera_dma_ctrl

Overview:
Sequences frame capture from the camera ping-pong FIFO read side into system memory. Claims each ready FIFO block, pops words one at a time and issues single-word acked memory writes at incrementing addresses. Counts words per frame and alternates between two frame buffers. Reports completion, overflow and abort status to the wishbone register slave.

Parameters:
ADDR_WIDTH, 32, memory byte-address width
SIZE_WIDTH, 24, width of the FIFO block-size field
ADDR_STEP, 4, byte increment per 32-bit word

Ports:
clk  in  1  system clock; the FIFO read side and the memory port are both in this domain
rst  in  1  asynchronous, active-low reset (rst=0 resets)
i_start  in  1  one-cycle pulse that arms one frame capture
i_enable  in  1  level; deasserting it aborts the frame in progress
i_continuous  in  1  re-arm automatically after each frame
i_frame_words  in  32  words per frame, latched at arm
i_base_addr0  in  ADDR_WIDTH  base address of frame buffer 0
i_base_addr1  in  ADDR_WIDTH  base address of frame buffer 1
i_clear_status  in  1  pulse; clears the sticky status bits
o_busy  out  1  high from arm until return to IDLE
o_frame_done  out  1  one-cycle pulse per completed frame
o_frame_index  out  1  buffer that the last completed frame was written to
o_overflow  out  1  sticky; FIFO words were discarded after the frame was full
o_aborted  out  1  sticky; a frame was aborted by i_enable=0
o_words_written  out  32  words written in the current/last frame
i_rfifo_ready  in  1  a read block is available
o_rfifo_activate  out  1  claims the ready block
i_rfifo_size  in  SIZE_WIDTH  word count of the claimed block
o_rfifo_strobe  out  1  pops the current word
i_rfifo_data  in  32  current word; valid while activate is high
o_mem_req  out  1  write request
o_mem_addr  out  ADDR_WIDTH  write byte address
o_mem_data  out  32  write data
i_mem_ack  in  1  one-cycle write acknowledge

Behaviour:
- Reset: all outputs 0; state IDLE; buf_sel=0.
- States: IDLE, WAIT_FIFO, READ, WRITE, RELEASE, DONE.
- IDLE, on i_start && i_enable:
  - if i_frame_words==0: ignore, stay IDLE.
  - otherwise latch frame_words; addr=base[buf_sel]; words=0; o_busy=1; go to WAIT_FIFO.
  - i_start while busy is ignored.
- WAIT_FIFO, on i_rfifo_ready && !o_rfifo_activate: set activate=1; latch remain=i_rfifo_size; go to READ.
- READ:
  - remain==0: go to RELEASE.
  - words<frame_words and not aborting: o_mem_data<=i_rfifo_data; o_rfifo_strobe pulses 1 cycle; o_mem_req=1 next cycle; go to WRITE.
  - otherwise (frame full or aborting): strobe without a write; remain--. If the frame is full, set o_overflow.
  - Strobes are never issued on back-to-back cycles; at least 1 cycle separates them so the FIFO data settles.
- WRITE:
  - req, addr and data held stable until i_mem_ack.
  - On ack: req<=0; addr+=ADDR_STEP (wraps mod 2^ADDR_WIDTH); words++; remain--; go to READ.
  - Minimum 3 cycles per word.
- RELEASE: activate<=0. If words==frame_words go to DONE; else if aborting go to IDLE (o_busy=0, o_aborted=1); else go to WAIT_FIFO.
- DONE:
  - o_frame_done=1 for 1 cycle; o_frame_index=buf_sel; buf_sel toggles.
  - If i_continuous && i_enable: re-latch frame_words and base[new buf_sel]; go to WAIT_FIFO.
  - Else go to IDLE with o_busy=0.
- Abort: i_enable=0 sets the aborting flag.
  - An outstanding o_mem_req is never dropped before its ack.
  - The rest of the claimed block is drained without writes, then released.
  - In WAIT_FIFO, abort goes to IDLE immediately.
- o_words_written mirrors words; cleared at arm.
- i_clear_status clears o_overflow/o_aborted. A set in the same cycle wins.
- Frame end mid-block: the excess words in that block are discarded and o_overflow is set.

Decomposition:
- Package sf_camera_pkg holds the state encodings, ADDR_STEP, and the status bit positions shared with the wishbone slave register map.
- No sub-module; a single FSM plus counters.

Test Plan:
- Single block: frame_words=8, one 8-word block, base0=0x1000, ack after 2 cycles -> writes at 0x1000..0x101C with data in order, 1 frame_done pulse, o_frame_index=0, o_busy=0 afterwards.
- Multi-block: frame_words=12, blocks of 4 → 12 words written, 3 activate/release cycles, words_written=12.
- Continuous ping-pong: base0=0x0, base1=0x8000, frame_words=4, 2 frames -> second frame written at 0x8000, o_frame_index 0 then 1.
- Overflow: frame_words=6, one 8-word block -> 6 writes, 8 strobes, o_overflow=1; i_clear_status -> 0.
- Abort: drop i_enable while req is pending with ack delayed 5 cycles -> req held until ack, block drained, o_aborted=1, no frame_done, IDLE.
- Reset mid-WRITE: rst=0 -> all outputs 0 asynchronously, i_start works again after release.

Source files
------------

// File: rtl/sf_camera_pkg.sv
// Shared definitions for the camera DMA sequencer: FSM encoding, address step
// and the status bit layout that the wishbone register slave exposes.
package sf_camera_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FIFO = 3'd1,
        ST_READ      = 3'd2,
        ST_WRITE     = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_DONE      = 3'd5
    } sf_state_e;

    localparam int SF_ADDR_STEP = 4;

    localparam int STAT_BUSY_BIT     = 0;
    localparam int STAT_DONE_BIT     = 1;
    localparam int STAT_INDEX_BIT    = 2;
    localparam int STAT_OVERFLOW_BIT = 3;
    localparam int STAT_ABORTED_BIT  = 4;
    localparam int STAT_WIDTH        = 5;

    function automatic logic [STAT_WIDTH-1:0] sf_pack_status(
        input logic busy,
        input logic done,
        input logic index,
        input logic overflow,
        input logic aborted
    );
        logic [STAT_WIDTH-1:0] s;
        s                    = '0;
        s[STAT_BUSY_BIT]     = busy;
        s[STAT_DONE_BIT]     = done;
        s[STAT_INDEX_BIT]    = index;
        s[STAT_OVERFLOW_BIT] = overflow;
        s[STAT_ABORTED_BIT]  = aborted;
        return s;
    endfunction

endpackage

// File: rtl/sf_camera_dma_ctrl.sv
// Moves camera ping-pong FIFO blocks into alternating frame buffers using
// single-word acknowledged memory writes; reports done/overflow/abort status.
module sf_camera_dma_ctrl
    import sf_camera_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int SIZE_WIDTH = 24,
    parameter int ADDR_STEP  = SF_ADDR_STEP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_enable,
    input  logic                  i_continuous,
    input  logic [31:0]           i_frame_words,
    input  logic [ADDR_WIDTH-1:0] i_base_addr0,
    input  logic [ADDR_WIDTH-1:0] i_base_addr1,
    input  logic                  i_clear_status,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_frame_index,
    output logic                  o_overflow,
    output logic                  o_aborted,
    output logic [31:0]           o_words_written,
    input  logic                  i_rfifo_ready,
    output logic                  o_rfifo_activate,
    input  logic [SIZE_WIDTH-1:0] i_rfifo_size,
    output logic                  o_rfifo_strobe,
    input  logic [31:0]           i_rfifo_data,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_data,
    input  logic                  i_mem_ack
);

    sf_state_e             state_q, state_d;
    logic                  buf_sel_q, buf_sel_d;
    logic [31:0]           frame_words_q, frame_words_d;
    logic [31:0]           words_q, words_d;
    logic [SIZE_WIDTH-1:0] remain_q, remain_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  req_q, req_d;
    logic                  activate_q, activate_d;
    logic                  strobe_q, strobe_d;
    logic                  settle_q, settle_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  index_q, index_d;
    logic                  overflow_q, overflow_d;
    logic                  aborted_q, aborted_d;
    logic                  aborting_q, aborting_d;

    logic                  abort_now;
    logic                  ovf_set;
    logic                  abort_set;
    logic                  frame_full;

    assign abort_now  = aborting_q | ~i_enable;
    assign frame_full = (words_q >= frame_words_q);

    always_comb begin
        state_d       = state_q;
        buf_sel_d     = buf_sel_q;
        frame_words_d = frame_words_q;
        words_d       = words_q;
        remain_d      = remain_q;
        addr_d        = addr_q;
        data_d        = data_q;
        req_d         = req_q;
        activate_d    = activate_q;
        strobe_d      = 1'b0;
        settle_d      = settle_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        index_d       = index_q;
        aborting_d    = aborting_q;
        ovf_set       = 1'b0;
        abort_set     = 1'b0;

        if (busy_q && !i_enable) begin
            aborting_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                aborting_d = 1'b0;
                if (i_start && i_enable && (i_frame_words != '0)) begin
                    frame_words_d = i_frame_words;
                    addr_d        = buf_sel_q ? i_base_addr1 : i_base_addr0;
                    words_d       = '0;
                    busy_d        = 1'b1;
                    state_d       = ST_WAIT_FIFO;
                end
            end

            ST_WAIT_FIFO: begin
                if (abort_now) begin
                    busy_d     = 1'b0;
                    abort_set  = 1'b1;
                    aborting_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (i_rfifo_ready && !activate_q) begin
                    activate_d = 1'b1;
                    remain_d   = i_rfifo_size;
                    settle_d   = 1'b1;
                    state_d    = ST_READ;
                end
            end

            // settle_q inserts an idle cycle after every pop so FIFO data is stable
            ST_READ: begin
                if (settle_q) begin
                    settle_d = 1'b0;
                end else if (remain_q == '0) begin
                    state_d = ST_RELEASE;
                end else if (!frame_full && !abort_now) begin
                    data_d   = i_rfifo_data;
                    strobe_d = 1'b1;
                    req_d    = 1'b1;
                    state_d  = ST_WRITE;
                end else begin
                    strobe_d = 1'b1;
                    remain_d = remain_q - SIZE_WIDTH'(1);
                    settle_d = 1'b1;
                    ovf_set  = frame_full;
                end
            end

            ST_WRITE: begin
                if (i_mem_ack) begin
                    req_d    = 1'b0;
                    addr_d   = addr_q + ADDR_WIDTH'(ADDR_STEP);
                    words_d  = words_q + 32'd1;
                    remain_d = remain_q - SIZE_WIDTH'(1);
                    settle_d = 1'b1;
                    state_d  = ST_READ;
                end
            end

            ST_RELEASE: begin
                activate_d = 1'b0;
                if (words_q == frame_words_q) begin
                    state_d = ST_DONE;
                end else if (abort_now) begin
                    busy_d     = 1'b0;
                    abort_set  = 1'b1;
                    aborting_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_FIFO;
                end
            end

            ST_DONE: begin
                done_d     = 1'b1;
                index_d    = buf_sel_q;
                buf_sel_d  = ~buf_sel_q;
                aborting_d = 1'b0;
                if (i_continuous && i_enable && (i_frame_words != '0)) begin
                    frame_words_d = i_frame_words;
                    addr_d        = buf_sel_q ? i_base_addr0 : i_base_addr1;
                    words_d       = '0;
                    state_d       = ST_WAIT_FIFO;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // a set in the same cycle as a clear keeps the bit
        overflow_d = (overflow_q & ~i_clear_status) | ovf_set;
        aborted_d  = (aborted_q  & ~i_clear_status) | abort_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            buf_sel_q     <= 1'b0;
            frame_words_q <= '0;
            words_q       <= '0;
            remain_q      <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            req_q         <= 1'b0;
            activate_q    <= 1'b0;
            strobe_q      <= 1'b0;
            settle_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            index_q       <= 1'b0;
            overflow_q    <= 1'b0;
            aborted_q     <= 1'b0;
            aborting_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_sel_q     <= buf_sel_d;
            frame_words_q <= frame_words_d;
            words_q       <= words_d;
            remain_q      <= remain_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            req_q         <= req_d;
            activate_q    <= activate_d;
            strobe_q      <= strobe_d;
            settle_q      <= settle_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            index_q       <= index_d;
            overflow_q    <= overflow_d;
            aborted_q     <= aborted_d;
            aborting_q    <= aborting_d;
        end
    end

    assign o_busy           = busy_q;
    assign o_frame_done     = done_q;
    assign o_frame_index    = index_q;
    assign o_overflow       = overflow_q;
    assign o_aborted        = aborted_q;
    assign o_words_written  = words_q;
    assign o_rfifo_activate = activate_q;
    assign o_rfifo_strobe   = strobe_q;
    assign o_mem_req        = req_q;
    assign o_mem_addr       = addr_q;
    assign o_mem_data       = data_q;

endmodule
